// File: rtl/ex_md_stage_if.sv
// ID/EX-to-EX/MEM bus of the execute stage: issue fields, forwarding and
// stage control in, EX/MEM register fields and hazard/forward feedback out.
interface ex_md_stage_if #(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 4,
    parameter int MEM_OP_W = 2
);
    logic                stall;
    logic                flush;
    logic                id_en;
    logic [XLEN-1:0]     id_pc;
    logic                id_md_en;
    logic [2:0]          id_md_op;
    logic [ALU_OP_W-1:0] id_alu_op;
    logic [XLEN-1:0]     id_alu_in_0;
    logic [XLEN-1:0]     id_alu_in_1;
    logic                ex_rs1_fwd_en;
    logic                ex_rs2_fwd_en;
    logic [XLEN-1:0]     mem_fwd_data;
    logic [MEM_OP_W-1:0] id_mem_op;
    logic [XLEN-1:0]     id_mem_wr_data;
    logic [4:0]          id_rd_addr;
    logic                id_gpr_we_;

    logic                md_busy;
    logic [XLEN-1:0]     fwd_data;
    logic                ex_en;
    logic [XLEN-1:0]     ex_pc;
    logic [MEM_OP_W-1:0] ex_mem_op;
    logic [XLEN-1:0]     ex_mem_wr_data;
    logic [4:0]          ex_rd_addr;
    logic                ex_gpr_we_;
    logic [XLEN-1:0]     ex_out;

    modport master (
        output stall, flush, id_en, id_pc, id_md_en, id_md_op, id_alu_op,
               id_alu_in_0, id_alu_in_1, ex_rs1_fwd_en, ex_rs2_fwd_en,
               mem_fwd_data, id_mem_op, id_mem_wr_data, id_rd_addr, id_gpr_we_,
        input  md_busy, fwd_data, ex_en, ex_pc, ex_mem_op, ex_mem_wr_data,
               ex_rd_addr, ex_gpr_we_, ex_out
    );

    modport slave (
        input  stall, flush, id_en, id_pc, id_md_en, id_md_op, id_alu_op,
               id_alu_in_0, id_alu_in_1, ex_rs1_fwd_en, ex_rs2_fwd_en,
               mem_fwd_data, id_mem_op, id_mem_wr_data, id_rd_addr, id_gpr_we_,
        output md_busy, fwd_data, ex_en, ex_pc, ex_mem_op, ex_mem_wr_data,
               ex_rd_addr, ex_gpr_we_, ex_out
    );
endinterface

// File: rtl/ex_md_stage.sv
// Execute stage: single-cycle ALU plus an iterative RV M-extension unit
// (shift-add multiply, restoring divide) feeding the EX/MEM register.
module ex_md_stage #(
    parameter int XLEN     = 32,
    parameter int CNT_W    = $clog2(XLEN) + 1,
    parameter int ALU_OP_W = 4,
    parameter int MEM_OP_W = 2,
    parameter logic [MEM_OP_W-1:0] MEM_OP_NOP = '0
) (
    input logic          clk,
    input logic          reset,
    ex_md_stage_if.slave bus
);

    localparam int SH_W = $clog2(XLEN);

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_OP_NOP, ALU_OP_ADD, ALU_OP_SUB, ALU_OP_AND, ALU_OP_OR, ALU_OP_XOR,
        ALU_OP_SLL, ALU_OP_SRL, ALU_OP_SRA, ALU_OP_SLT, ALU_OP_SLTU, ALU_OP_PASS
    } alu_op_e;

    typedef enum logic [2:0] {
        MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
    } md_op_e;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e            state, state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   b_mag;
    md_op_e            op_r;
    logic              neg_r;
    logic [XLEN-1:0]   res_r;

    logic [XLEN-1:0]   rs1, rs2, st_data, alu_res, st_out;
    logic [SH_W-1:0]   shamt;
    alu_op_e           alu_op;
    md_op_e            md_op;
    logic              md_req, last_iter;
    logic              a_sgn, b_sgn, res_neg_in, div0, ovf, corner;
    logic [XLEN-1:0]   a_mag_in, b_mag_in, preset;

    logic [XLEN:0]     mul_sum, div_trial;
    logic [2*XLEN-1:0] acc_nx, prod_fix;
    logic [XLEN-1:0]   div_val, div_fix, fin;

    assign rs1     = bus.ex_rs1_fwd_en ? bus.mem_fwd_data : bus.id_alu_in_0;
    assign rs2     = bus.ex_rs2_fwd_en ? bus.mem_fwd_data : bus.id_alu_in_1;
    assign st_data = bus.ex_rs2_fwd_en ? bus.mem_fwd_data : bus.id_mem_wr_data;
    assign shamt   = bus.id_alu_in_1[SH_W-1:0];
    assign alu_op  = alu_op_e'(bus.id_alu_op);
    assign md_op   = md_op_e'(bus.id_md_op);

    // The ALU second input is never forwarded: it may carry an immediate.
    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_OP_ADD:  alu_res = rs1 + bus.id_alu_in_1;
            ALU_OP_SUB:  alu_res = rs1 - bus.id_alu_in_1;
            ALU_OP_AND:  alu_res = rs1 & bus.id_alu_in_1;
            ALU_OP_OR:   alu_res = rs1 | bus.id_alu_in_1;
            ALU_OP_XOR:  alu_res = rs1 ^ bus.id_alu_in_1;
            ALU_OP_SLL:  alu_res = rs1 << shamt;
            ALU_OP_SRL:  alu_res = rs1 >> shamt;
            ALU_OP_SRA:  alu_res = $unsigned($signed(rs1) >>> shamt);
            ALU_OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(rs1) < $signed(bus.id_alu_in_1)};
            ALU_OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, rs1 < bus.id_alu_in_1};
            ALU_OP_PASS: alu_res = bus.id_alu_in_1;
            default:     alu_res = '0;
        endcase
    end

    assign md_req = bus.id_en & bus.id_md_en & ~bus.flush & (state == IDLE);

    always_comb begin
        a_sgn = rs1[XLEN-1] & (md_op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
        b_sgn = rs2[XLEN-1] & (md_op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM});
        a_mag_in = a_sgn ? (~rs1 + 1'b1) : rs1;
        b_mag_in = b_sgn ? (~rs2 + 1'b1) : rs2;
        res_neg_in = (md_op inside {MD_REM, MD_REMU}) ? a_sgn : (a_sgn ^ b_sgn);
        div0 = bus.id_md_op[2] & (rs2 == '0);
        ovf  = (md_op inside {MD_DIV, MD_REM}) &
               (rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (rs2 == '1);
        corner = div0 | ovf;
        if (bus.id_md_op[1])
            preset = div0 ? rs1 : '0;
        else
            preset = div0 ? '1 : rs1;
    end

    // acc is {high, low}: product accumulator for multiply, {remainder, quotient} for divide.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? b_mag : {XLEN{1'b0}})};
        div_trial = acc[2*XLEN-1:XLEN-1] - {1'b0, b_mag};
        if (op_r[2])
            acc_nx = div_trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                     : {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        else
            acc_nx = {mul_sum, acc[XLEN-1:1]};
        prod_fix = neg_r ? (~acc_nx + 1'b1) : acc_nx;
        div_val  = op_r[1] ? acc_nx[2*XLEN-1:XLEN] : acc_nx[XLEN-1:0];
        div_fix  = neg_r ? (~div_val + 1'b1) : div_val;
        if (op_r[2])
            fin = div_fix;
        else if (op_r == MD_MUL)
            fin = prod_fix[XLEN-1:0];
        else
            fin = prod_fix[2*XLEN-1:XLEN];
    end

    assign last_iter = (cnt == CNT_W'(XLEN - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (md_req) state_nx = corner ? DONE : BUSY;
            BUSY:    if (last_iter) state_nx = DONE;
            DONE:    if (!bus.stall) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (bus.flush) state_nx = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            acc   <= '0;
            b_mag <= '0;
            op_r  <= MD_MUL;
            neg_r <= 1'b0;
            res_r <= '0;
        end else if (state == IDLE && md_req) begin
            cnt   <= '0;
            acc   <= {{XLEN{1'b0}}, a_mag_in};
            b_mag <= b_mag_in;
            op_r  <= md_op;
            neg_r <= res_neg_in;
            if (corner) res_r <= preset;
        end else if (state == BUSY && !bus.flush) begin
            cnt <= cnt + 1'b1;
            acc <= acc_nx;
            if (last_iter) res_r <= fin;
        end
    end

    assign st_out       = (state == DONE) ? res_r : alu_res;
    assign bus.fwd_data = st_out;
    assign bus.md_busy  = md_req | (state == BUSY);

    always_ff @(posedge clk or posedge reset) begin
        if (reset || bus.flush) begin
            bus.ex_en          <= 1'b0;
            bus.ex_pc          <= '0;
            bus.ex_mem_op      <= MEM_OP_NOP;
            bus.ex_mem_wr_data <= '0;
            bus.ex_rd_addr     <= '0;
            bus.ex_gpr_we_     <= 1'b1;
            bus.ex_out         <= '0;
        end else if (bus.stall) begin
            bus.ex_en <= bus.ex_en;
        end else if (bus.md_busy) begin
            bus.ex_en          <= 1'b0;
            bus.ex_pc          <= '0;
            bus.ex_mem_op      <= MEM_OP_NOP;
            bus.ex_mem_wr_data <= '0;
            bus.ex_rd_addr     <= '0;
            bus.ex_gpr_we_     <= 1'b1;
            bus.ex_out         <= '0;
        end else begin
            bus.ex_en          <= bus.id_en;
            bus.ex_pc          <= bus.id_pc;
            bus.ex_mem_op      <= bus.id_mem_op;
            bus.ex_mem_wr_data <= st_data;
            bus.ex_rd_addr     <= bus.id_rd_addr;
            bus.ex_gpr_we_     <= bus.id_gpr_we_;
            bus.ex_out         <= st_out;
        end
    end

endmodule
